// File: rtl/seg7_pkg.sv
// ============================================================================
// Module   : seg7_pkg
// Brief    : State encoding and segment pattern constants for seg7_decoder.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Segment order is {a,b,c,d,e,f,g}, a in the MSB.
    localparam logic [6:0] c_SEG_0 = 7'b1111110;
    localparam logic [6:0] c_SEG_1 = 7'b0110000;
    localparam logic [6:0] c_SEG_2 = 7'b1101101;
    localparam logic [6:0] c_SEG_3 = 7'b1111001;
    localparam logic [6:0] c_SEG_4 = 7'b0110011;
    localparam logic [6:0] c_SEG_5 = 7'b1011011;
    localparam logic [6:0] c_SEG_6 = 7'b1011111;
    localparam logic [6:0] c_SEG_7 = 7'b1110000;
    localparam logic [6:0] c_SEG_8 = 7'b1111111;
    localparam logic [6:0] c_SEG_9 = 7'b1111011;
    localparam logic [6:0] c_SEG_A = 7'b1110111;
    localparam logic [6:0] c_SEG_B = 7'b0011111;
    localparam logic [6:0] c_SEG_C = 7'b1001110;
    localparam logic [6:0] c_SEG_D = 7'b0111101;
    localparam logic [6:0] c_SEG_E = 7'b1001111;
    localparam logic [6:0] c_SEG_F = 7'b1000111;

    localparam logic [6:0] c_BLANK = 7'b0000000;

    localparam logic [15:0][6:0] c_SEG_TABLE = {
        c_SEG_F, c_SEG_E, c_SEG_D, c_SEG_C,
        c_SEG_B, c_SEG_A, c_SEG_9, c_SEG_8,
        c_SEG_7, c_SEG_6, c_SEG_5, c_SEG_4,
        c_SEG_3, c_SEG_2, c_SEG_1, c_SEG_0
    };

endpackage

`default_nettype wire

// File: rtl/seg7_lookup.sv
// ============================================================================
// Module   : seg7_lookup
// Brief    : Combinational 7-segment pattern to {legal, blank, value} decode.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seg7_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_legal,
    output logic       o_blank,
    output logic [3:0] o_value
);

    always_comb begin
        o_legal = 1'b0;
        o_value = 4'd0;
        o_blank = (i_seg == c_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (i_seg == c_SEG_TABLE[i]) begin
                o_legal = 1'b1;
                o_value = 4'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/seg7_decoder.sv
// ============================================================================
// Module   : seg7_decoder
// Brief    : Waits for a stable 7-segment pattern, then decodes it to hex.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seg7_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE = 4,
    parameter int ERR_W  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             s1,
    input  logic             s2,
    input  logic             s3,
    input  logic             s4,
    input  logic             s5,
    input  logic             s6,
    input  logic             s7,
    output logic             A,
    output logic             B,
    output logic             C,
    output logic             D,
    output logic             valid,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic             locked
);

    localparam logic [7:0] c_STABLE = 8'(STABLE);

    state_t             r_state;
    logic [6:0]         r_cur;
    logic [7:0]         r_run;
    logic [3:0]         r_value;
    logic               r_valid;
    logic               r_err;
    logic               r_locked;
    logic [ERR_W-1:0]   r_err_count;

    logic [6:0]         w_pat;
    logic               w_change;
    logic               w_legal;
    logic               w_blank;
    logic [3:0]         w_value;

    assign w_pat    = {s1, s2, s3, s4, s5, s6, s7};
    assign w_change = en && (w_pat != r_cur);

    seg7_lookup u_lookup (
        .i_seg   (r_cur),
        .o_legal (w_legal),
        .o_blank (w_blank),
        .o_value (w_value)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cur       <= 7'd0;
            r_run       <= 8'd0;
            r_value     <= 4'd0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_locked    <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_cur   <= w_pat;
                        r_run   <= 8'd1;
                        r_state <= TRACK;
                    end
                end
                TRACK: begin
                    // A changed sample always beats a decision due on the same edge.
                    if (w_change) begin
                        r_cur <= w_pat;
                        r_run <= 8'd1;
                    end else if (r_run == c_STABLE) begin
                        r_state  <= HOLD;
                        r_locked <= 1'b1;
                        if (w_legal) begin
                            r_value <= w_value;
                            r_valid <= 1'b1;
                        end else if (!w_blank) begin
                            r_err <= 1'b1;
                            if (r_err_count != '1) begin
                                r_err_count <= r_err_count + ERR_W'(1);
                            end
                        end
                    end else if (en) begin
                        r_run <= r_run + 8'd1;
                    end
                end
                HOLD: begin
                    if (w_change) begin
                        r_cur    <= w_pat;
                        r_run    <= 8'd1;
                        r_state  <= TRACK;
                        r_locked <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign {A, B, C, D} = r_value;
    assign valid        = r_valid;
    assign err          = r_err;
    assign err_count    = r_err_count;
    assign locked       = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_seg7_decoder.sv
// ============================================================================
// Module   : tb_seg7_decoder
// Brief    : Randomized and directed bench for seg7_decoder against a reference model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seg7_decoder;

    localparam int N = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       en    = 1'b0;
    logic [6:0] pat   = 7'd0;

    logic       A0, B0, C0, D0, valid0, err0, locked0;
    logic [1:0] err_count0;
    logic       A1, B1, C1, D1, valid1, err1, locked1;
    logic [7:0] err_count1;

    always #5 clock = ~clock;

    seg7_decoder #(.STABLE(4), .ERR_W(2)) dut0 (
        .clock(clock), .reset(reset), .en(en),
        .s1(pat[6]), .s2(pat[5]), .s3(pat[4]), .s4(pat[3]),
        .s5(pat[2]), .s6(pat[1]), .s7(pat[0]),
        .A(A0), .B(B0), .C(C0), .D(D0),
        .valid(valid0), .err(err0), .err_count(err_count0), .locked(locked0)
    );

    seg7_decoder #(.STABLE(1), .ERR_W(8)) dut1 (
        .clock(clock), .reset(reset), .en(en),
        .s1(pat[6]), .s2(pat[5]), .s3(pat[4]), .s4(pat[3]),
        .s5(pat[2]), .s6(pat[1]), .s7(pat[0]),
        .A(A1), .B(B1), .C(C1), .D(D1),
        .valid(valid1), .err(err1), .err_count(err_count1), .locked(locked1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: hex digit glyphs in order 0..F
    logic [6:0] seg_tbl [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Returns 0..15 for a digit, 16 for blank, -1 for anything else.
    function automatic int ref_decode(input logic [6:0] p);
        int r;
        r = (p == 7'd0) ? 16 : -1;
        for (int i = 0; i < 16; i++) if (seg_tbl[i] == p) r = i;
        return r;
    endfunction

    int         m_stable [N] = '{4, 1};
    int         m_max    [N] = '{3, 255};
    bit         m_have   [N];
    bit         m_dec    [N];
    logic [6:0] m_cur    [N];
    int         m_run    [N];
    int         m_val    [N];
    int         m_cnt    [N];
    bit         m_valid  [N];
    bit         m_err    [N];

    task automatic model_reset(input int k);
        m_have[k] = 0; m_dec[k] = 0; m_cur[k] = 7'd0; m_run[k] = 0;
        m_val[k] = 0; m_cnt[k] = 0; m_valid[k] = 0; m_err[k] = 0;
    endtask

    task automatic model_edge(input int k, input bit e, input logic [6:0] p);
        int d;
        m_valid[k] = 0;
        m_err[k]   = 0;
        if (!m_have[k]) begin
            if (e) begin m_have[k] = 1; m_cur[k] = p; m_run[k] = 1; end
        end else if (e && p != m_cur[k]) begin
            m_cur[k] = p; m_run[k] = 1; m_dec[k] = 0;
        end else if (!m_dec[k]) begin
            if (m_run[k] == m_stable[k]) begin
                m_dec[k] = 1;
                d = ref_decode(m_cur[k]);
                if (d >= 0 && d < 16) begin
                    m_valid[k] = 1; m_val[k] = d;
                end else if (d < 0) begin
                    m_err[k] = 1;
                    if (m_cnt[k] < m_max[k]) m_cnt[k]++;
                end
            end else if (e) begin
                m_run[k]++;
            end
        end
    endtask

    int v0cnt = 0;
    int e0cnt = 0;

    task automatic compare_all();
        check("d0_valid",  32'(valid0),             32'(m_valid[0]));
        check("d0_err",    32'(err0),               32'(m_err[0]));
        check("d0_value",  32'({A0, B0, C0, D0}),   m_val[0]);
        check("d0_errcnt", 32'(err_count0),         m_cnt[0]);
        check("d0_locked", 32'(locked0),            32'(m_dec[0]));
        check("d1_valid",  32'(valid1),             32'(m_valid[1]));
        check("d1_err",    32'(err1),               32'(m_err[1]));
        check("d1_value",  32'({A1, B1, C1, D1}),   m_val[1]);
        check("d1_errcnt", 32'(err_count1),         m_cnt[1]);
        check("d1_locked", 32'(locked1),            32'(m_dec[1]));
        if (valid0 === 1'b1) v0cnt++;
        if (err0 === 1'b1)   e0cnt++;
    endtask

    task automatic step(input bit r, input bit e, input logic [6:0] p);
        @(negedge clock);
        reset = r; en = e; pat = p;
        @(posedge clock);
        for (int k = 0; k < N; k++) begin
            if (r) model_reset(k);
            else   model_edge(k, e, p);
        end
        #1;
        compare_all();
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, p);
    endtask

    task automatic clear_counts();
        v0cnt = 0; e0cnt = 0;
    endtask

    int sat_exp [5] = '{1, 2, 3, 3, 3};
    logic [6:0] sat_pat [5] = '{7'b0000011, 7'b0000101, 7'b0001001, 7'b0010001, 7'b0100001};
    bit en_gap [6] = '{1, 0, 1, 0, 1, 1};

    initial begin
        for (int k = 0; k < N; k++) model_reset(k);

        step(1'b1, 1'b0, 7'd0);
        step(1'b1, 1'b0, 7'd0);
        check("rst_value", 32'({A0, B0, C0, D0}), 0);

        // Digit 5 settles and is reported once.
        clear_counts();
        hold(7'b1011011, 6);
        check("five_valid_cnt", v0cnt, 1);
        check("five_value", 32'({A0, B0, C0, D0}), 5);
        check("five_locked", 32'(locked0), 1);

        // Glitch in the middle of a settling 3.
        clear_counts();
        hold(7'b1111001, 2);
        hold(7'b0110000, 1);
        hold(7'b1111001, 5);
        step(1'b0, 1'b0, 7'b1111001);
        check("glitch_valid_cnt", v0cnt, 1);
        check("glitch_err_cnt", e0cnt, 0);
        check("glitch_value", 32'({A0, B0, C0, D0}), 3);

        // Illegal then blank.
        clear_counts();
        hold(7'b0000001, 5);
        check("illegal_err_cnt", e0cnt, 1);
        check("illegal_valid_cnt", v0cnt, 0);
        check("illegal_value", 32'({A0, B0, C0, D0}), 3);
        clear_counts();
        hold(7'b0000000, 5);
        check("blank_strobes", v0cnt + e0cnt, 0);
        check("blank_locked", 32'(locked0), 1);

        // Saturation of the 2-bit error counter.
        step(1'b1, 1'b0, 7'd0);
        step(1'b1, 1'b0, 7'd0);
        for (int i = 0; i < 5; i++) begin
            hold(sat_pat[i], 4);
            step(1'b0, 1'b0, sat_pat[i]);
            check("sat_errcnt", 32'(err_count0), sat_exp[i]);
        end

        // Enable gaps pause the run count.
        clear_counts();
        for (int i = 0; i < 6; i++) step(1'b0, en_gap[i], 7'b1000111);
        check("gap_early_valid", v0cnt, 0);
        step(1'b0, 1'b0, 7'b1000111);
        check("gap_valid_cnt", v0cnt, 1);
        check("gap_value", 32'({A0, B0, C0, D0}), 15);

        // Change at the decision edge restarts tracking.
        clear_counts();
        hold(7'b1101101, 4);
        hold(7'b0110011, 1);
        check("simul_no_strobe", v0cnt + e0cnt, 0);
        hold(7'b0110011, 3);
        check("simul_restart_wait", v0cnt, 0);
        hold(7'b0110011, 1);
        check("simul_valid_cnt", v0cnt, 1);
        check("simul_value", 32'({A0, B0, C0, D0}), 4);

        // Reset part-way through tracking.
        clear_counts();
        hold(7'b1011111, 3);
        step(1'b1, 1'b1, 7'b1011111);
        step(1'b1, 1'b1, 7'b1011111);
        check("midrst_value", 32'({A0, B0, C0, D0}), 0);
        hold(7'b1011111, 4);
        check("midrst_full_wait", v0cnt, 0);
        hold(7'b1011111, 1);
        check("midrst_valid_cnt", v0cnt, 1);

        // Randomized bursts.
        for (int b = 0; b < 120; b++) begin
            int sel;
            int len;
            logic [6:0] p;
            sel = $urandom_range(0, 9);
            if (sel <= 5)      p = seg_tbl[$urandom_range(0, 15)];
            else if (sel == 6) p = 7'd0;
            else               p = 7'($urandom_range(0, 127));
            len = $urandom_range(1, 7);
            if ($urandom_range(0, 39) == 0) begin
                step(1'b1, 1'b0, p);
            end
            for (int i = 0; i < len; i++) begin
                step(1'b0, ($urandom_range(0, 3) != 0), p);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
